biu: RTL and testbench

Bus interface unit for the t8086 core. Sits directly upstream of the byte-organised `ram` and is its only master. It fetches instruction bytes into a prefetch queue for the decoder and serves execution-unit data accesses on the RAM's word-organised, even-aligned read and write ports. The RAM port has no byte lanes for odd addresses, so the BIU splits odd-address word accesses into multiple bus cycles and runs odd-byte writes as read-modify-write sequences.

---
 rtl/biu_pkg.sv | 22 ++
 rtl/biu_prefetch_queue.sv | 83 ++++++++
 rtl/biu.sv | 221 ++++++++++++++++++++++
 tb/tb_biu.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// ------------------------------------------------------------------
// biu_pkg: shared types and default parameters for the bus interface unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package biu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUS1 = 3'd1,
    ST_BUS2 = 3'd2,
    ST_BUS3 = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  localparam int unsigned QUEUE_DEPTH_DEF = 6;
  localparam logic [19:0] RESET_ADDR_DEF  = 20'hFFFF0;

endpackage

`default_nettype wire

// File: rtl/biu_prefetch_queue.sv
// ------------------------------------------------------------------
// prefetch_queue: circular instruction byte buffer, push 0/1/2, pop 1
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module prefetch_queue
  import biu_pkg::*;
#(
  parameter  int unsigned DEPTH = QUEUE_DEPTH_DEF,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      // single-byte pushes always carry their byte in the low half
      if (push_cnt != 2'd0) begin
        mem_d[wr_q] = push_data[7:0];
        wr_d        = nxt(wr_q);
      end
      if (push_cnt == 2'd2) begin
        mem_d[nxt(wr_q)] = push_data[15:8];
        wr_d             = nxt(nxt(wr_q));
      end
      if (do_pop) begin
        rd_d = nxt(rd_q);
      end
      count_d = count_q + CW'(push_cnt) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: 8'h00};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign head  = (count_q != '0) ? mem_q[rd_q] : 8'h00;
  assign count = count_q;
  assign free  = CW'(DEPTH) - count_q;

endmodule

`default_nettype wire

// File: rtl/biu.sv
// ------------------------------------------------------------------
// biu: t8086 bus interface unit - instruction prefetch and data accesses
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module biu
  import biu_pkg::*;
#(
  parameter  int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter  logic [19:0] RESET_ADDR  = RESET_ADDR_DEF,
  localparam int unsigned CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          q_flush,
  input  logic [19:0]   q_flush_addr,
  input  logic          q_pop,
  output logic          q_valid,
  output logic [7:0]    q_data,
  output logic [CW-1:0] q_count,
  input  logic          mem_req,
  input  logic          mem_wr,
  input  logic          mem_word,
  input  logic [19:0]   mem_addr,
  input  logic [15:0]   mem_wdata,
  output logic          mem_busy,
  output logic          mem_ack,
  output logic [15:0]   mem_rdata,
  output logic          ram_rd_en,
  output logic          ram_rd_we,
  output logic [19:0]   ram_rd_addr,
  input  logic [15:0]   ram_rd_data,
  output logic          ram_wr_en,
  output logic          ram_wr_we,
  output logic [19:0]   ram_wr_addr,
  output logic [15:0]   ram_wr_data
);

  state_e        state_q, state_d;
  logic [19:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic          word_q, word_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [7:0]    lat_q, lat_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [19:0]   fptr_q, fptr_d;

  logic [19:0]   e_addr;
  logic [19:0]   n_addr;
  logic          fetch_ok;
  logic [1:0]    push_cnt;
  logic [15:0]   push_data;
  logic [CW-1:0] q_free;

  prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (q_flush),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (q_pop),
    .head      (q_data),
    .count     (q_count),
    .free      (q_free)
  );

  // for an odd address, A+1 is the next even word
  assign e_addr = {addr_q[19:1], 1'b0};
  assign n_addr = e_addr + 20'd2;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    fptr_d      = fptr_q;
    ram_rd_en   = 1'b0;
    ram_rd_we   = 1'b0;
    ram_rd_addr = 20'h00000;
    ram_wr_en   = 1'b0;
    ram_wr_we   = 1'b0;
    ram_wr_addr = 20'h00000;
    ram_wr_data = 16'h0000;
    push_cnt    = 2'd0;
    push_data   = 16'h0000;
    fetch_ok    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          wr_d    = mem_wr;
          word_d  = mem_word;
          wdata_d = mem_wdata;
          state_d = ST_BUS1;
        end
      end
      ST_BUS1: begin
        if (!wr_q || addr_q[0]) begin
          ram_rd_en   = 1'b1;
          ram_rd_we   = 1'b1;
          ram_rd_addr = e_addr;
        end
        if (!wr_q) begin
          if (!addr_q[0]) begin
            rdata_d = word_q ? ram_rd_data : {8'h00, ram_rd_data[7:0]};
            state_d = ST_ACK;
          end else if (!word_q) begin
            rdata_d = {8'h00, ram_rd_data[15:8]};
            state_d = ST_ACK;
          end else begin
            lat_d   = ram_rd_data[15:8];
            state_d = ST_BUS2;
          end
        end else if (!addr_q[0]) begin
          ram_wr_en   = 1'b1;
          ram_wr_we   = word_q;
          ram_wr_addr = e_addr;
          ram_wr_data = word_q ? wdata_q : {8'h00, wdata_q[7:0]};
          state_d     = ST_ACK;
        end else begin
          lat_d   = ram_rd_data[7:0];
          state_d = ST_BUS2;
        end
      end
      ST_BUS2: begin
        if (!wr_q) begin
          ram_rd_en   = 1'b1;
          ram_rd_we   = 1'b1;
          ram_rd_addr = n_addr;
          rdata_d     = {ram_rd_data[7:0], lat_q};
          state_d     = ST_ACK;
        end else begin
          ram_wr_en   = 1'b1;
          ram_wr_we   = 1'b1;
          ram_wr_addr = e_addr;
          ram_wr_data = {wdata_q[7:0], lat_q};
          state_d     = word_q ? ST_BUS3 : ST_ACK;
        end
      end
      ST_BUS3: begin
        ram_wr_en   = 1'b1;
        ram_wr_we   = 1'b0;
        ram_wr_addr = n_addr;
        ram_wr_data = {8'h00, wdata_q[15:8]};
        state_d     = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // the read port is free for prefetch whenever no bus cycle owns it
    if ((state_q == ST_IDLE || state_q == ST_ACK) && !q_flush) begin
      fetch_ok = fptr_q[0] ? (q_free != '0) : (q_free >= CW'(2));
    end
    if (fetch_ok) begin
      ram_rd_en   = 1'b1;
      ram_rd_we   = 1'b1;
      ram_rd_addr = {fptr_q[19:1], 1'b0};
      if (fptr_q[0]) begin
        push_cnt  = 2'd1;
        push_data = {8'h00, ram_rd_data[15:8]};
        fptr_d    = fptr_q + 20'd1;
      end else begin
        push_cnt  = 2'd2;
        push_data = ram_rd_data;
        fptr_d    = fptr_q + 20'd2;
      end
    end
    if (q_flush) begin
      fptr_d = q_flush_addr;
    end

    // an aborted sequence must not leak a write during reset
    if (!rst_n) begin
      ram_rd_en   = 1'b0;
      ram_rd_we   = 1'b0;
      ram_rd_addr = 20'h00000;
      ram_wr_en   = 1'b0;
      ram_wr_we   = 1'b0;
      ram_wr_addr = 20'h00000;
      ram_wr_data = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 20'h00000;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      wdata_q <= 16'h0000;
      lat_q   <= 8'h00;
      rdata_q <= 16'h0000;
      fptr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      fptr_q  <= fptr_d;
    end
  end

  assign q_valid   = (q_count != '0);
  assign mem_busy  = (state_q != ST_IDLE);
  assign mem_ack   = (state_q == ST_ACK);
  assign mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_biu.sv
// ------------------------------------------------------------------
// tb_biu: scoreboard bench for biu against a byte-level memory model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_biu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        q_flush = 1'b0;
  logic [19:0] q_flush_addr = 20'h0;
  logic        q_pop = 1'b0;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [2:0]  q_count;
  logic        mem_req = 1'b0;
  logic        mem_wr = 1'b0;
  logic        mem_word = 1'b0;
  logic [19:0] mem_addr = 20'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic        mem_busy;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ram_rd_en, ram_rd_we, ram_wr_en, ram_wr_we;
  logic [19:0] ram_rd_addr, ram_wr_addr;
  logic [15:0] ram_rd_data, ram_wr_data;

  biu dut (
    .clk(clk), .rst_n(rst_n),
    .q_flush(q_flush), .q_flush_addr(q_flush_addr), .q_pop(q_pop),
    .q_valid(q_valid), .q_data(q_data), .q_count(q_count),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_word(mem_word),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_rd_en(ram_rd_en), .ram_rd_we(ram_rd_we), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_we(ram_wr_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte array behind word ports, preload through pl_*
  bit [7:0]    ram     [0:1048575];
  bit [7:0]    ref_mem [0:1048575];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr = 20'h0;
  logic [7:0]  pl_data = 8'h0;

  assign ram_rd_data = {ram[{ram_rd_addr[19:1], 1'b1}], ram[{ram_rd_addr[19:1], 1'b0}]};

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (ram_wr_en) begin
      ram[{ram_wr_addr[19:1], 1'b0}] <= ram_wr_data[7:0];
      if (ram_wr_we) ram[{ram_wr_addr[19:1], 1'b1}] <= ram_wr_data[15:8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        rd;
    bit [15:0] data;
    int        acc;
    int        ack;
  } exp_t;

  exp_t      sb[$];
  bit [19:0] exp_ptr = 20'hFFFF0;
  int        pops_checked = 0;

  // monitor: data-access completions and queue pops
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() != 0)
        chk("mem_busy", {31'b0, mem_busy}, {31'b0, (cyc > sb[0].acc && cyc <= sb[0].ack)});
      else
        chk("mem_busy_idle", {31'b0, mem_busy}, 32'd0);
      if (mem_ack) begin
        if (sb.size() == 0) begin
          chk("spurious_ack", {31'b0, mem_ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", e.ack == cyc ? 32'd0 : 32'(cyc - e.acc), 32'd0 + ((e.ack == cyc) ? 0 : (e.ack - e.acc)));
          if (e.rd) chk("mem_rdata", {16'h0, mem_rdata}, {16'h0, e.data});
        end
      end
      if (q_flush) begin
        exp_ptr = q_flush_addr;
      end else if (q_pop && q_valid) begin
        chk("q_data", {24'h0, q_data}, {24'h0, ref_mem[exp_ptr]});
        exp_ptr = exp_ptr + 20'd1;
        pops_checked++;
      end
    end
  end

  task automatic set_byte(input bit [19:0] a, input bit [7:0] v);
    ref_mem[a] = v;
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("ack_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_access(input bit wr, input bit word, input bit [19:0] a, input bit [15:0] wd);
    exp_t      e;
    bit [19:0] a1;
    int        n = 0;
    while ((sb.size() != 0 || mem_busy) && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || mem_busy) begin
      chk("busy_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    a1    = a + 20'd1;
    e.rd  = !wr;
    e.acc = cyc;
    if (!wr) begin
      e.data = word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      e.ack  = cyc + ((word && a[0]) ? 3 : 2);
    end else begin
      ref_mem[a] = wd[7:0];
      if (word) ref_mem[a1] = wd[15:8];
      e.data = 16'h0;
      e.ack  = cyc + (!a[0] ? 2 : (word ? 4 : 3));
    end
    sb.push_back(e);
    mem_req   = 1'b1;
    mem_wr    = wr;
    mem_word  = word;
    mem_addr  = a;
    mem_wdata = wd;
    tick();
    mem_req   = 1'b0;
    mem_wr    = 1'($urandom);
    mem_word  = 1'($urandom);
    mem_addr  = 20'($urandom);
    mem_wdata = 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] boot [6];
    boot = '{8'hEA, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    tick();
    for (int i = 0; i < 6; i++) set_byte(20'hFFFF0 + 20'(i), boot[i]);
    set_byte(20'h00100, 8'h11); set_byte(20'h00101, 8'h22);
    set_byte(20'h00102, 8'h33); set_byte(20'h00103, 8'h44);
    set_byte(20'h00203, 8'h34); set_byte(20'h00204, 8'h12);
    set_byte(20'h00300, 8'h66); set_byte(20'h00301, 8'h55);
    set_byte(20'hFFFFE, 8'h5A); set_byte(20'hFFFFF, 8'h77);
    set_byte(20'h00000, 8'h88); set_byte(20'h00001, 8'hC3);
    for (int i = 0; i < 6; i++) set_byte(20'h00400 + 20'(i), 8'h99 - 8'(i));
    for (int i = 0; i < 6; i++) set_byte(20'h00500 + 20'(i), 8'h71 + 8'(i));
    for (int i = 0; i < 2048; i++) set_byte(20'h20000 + 20'(i), 8'($urandom));
    for (int i = 0; i < 2048; i++) set_byte(20'h40000 + 20'(i), 8'($urandom));

    // reset state
    @(negedge clk);
    chk("rst_q_valid", {31'b0, q_valid}, 32'd0);
    chk("rst_q_data", {24'h0, q_data}, 32'd0);
    chk("rst_q_count", {29'h0, q_count}, 32'd0);
    chk("rst_mem", {14'h0, mem_busy, mem_ack, mem_rdata}, 32'd0);
    chk("rst_ram_rd", {10'h0, ram_rd_en, ram_rd_we, ram_rd_addr}, 32'd0);
    chk("rst_ram_wr", {10'h0, ram_wr_en, ram_wr_we, ram_wr_addr}, 32'd0);
    chk("rst_ram_wdata", {16'h0, ram_wr_data}, 32'd0);
    tick();
    rst_n = 1'b1;

    // boot fetch fills the queue in three word fetches
    repeat (6) tick();
    @(negedge clk);
    chk("boot_count", {29'h0, q_count}, 32'd6);
    chk("boot_head", {24'h0, q_data}, 32'hEA);
    chk("full_no_fetch", {31'b0, ram_rd_en}, 32'd0);
    tick();
    q_pop = 1'b1;
    repeat (6) tick();
    q_pop = 1'b0;

    // flush to an odd address: first push is a single byte
    q_flush = 1'b1;
    q_flush_addr = 20'h00101;
    tick();
    q_flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_count", {29'h0, q_count}, 32'd0);
    chk("flush_empty_valid", {31'b0, q_valid}, 32'd0);
    chk("odd_fetch_addr", {11'h0, ram_rd_en, ram_rd_addr}, {11'h0, 1'b1, 20'h00100});
    tick();
    @(negedge clk);
    chk("odd_push_count", {29'h0, q_count}, 32'd1);
    chk("odd_push_head", {24'h0, q_data}, 32'h22);
    chk("fetch_addr_102", {12'h0, ram_rd_addr}, 32'h00102);
    tick();
    @(negedge clk);
    chk("count_after_two", {29'h0, q_count}, 32'd3);
    chk("fetch_addr_104", {12'h0, ram_rd_addr}, 32'h00104);
    tick();
    q_pop = 1'b1;
    repeat (3) tick();
    q_pop = 1'b0;

    // directed data accesses
    do_access(1'b0, 1'b1, 20'h00203, 16'h0000);
    do_access(1'b1, 1'b0, 20'h00301, 16'h00AB);
    do_access(1'b0, 1'b1, 20'h00300, 16'h0000);
    do_access(1'b1, 1'b1, 20'hFFFFF, 16'hBEEF);
    do_access(1'b0, 1'b0, 20'hFFFFF, 16'h0000);
    do_access(1'b0, 1'b0, 20'h00000, 16'h0000);
    do_access(1'b0, 1'b0, 20'hFFFFE, 16'h0000);
    do_access(1'b0, 1'b0, 20'h00001, 16'h0000);
    do_access(1'b0, 1'b1, 20'hFFFFF, 16'h0000);
    drain();

    // flush with a pop and an eligible fetch in the same cycle
    q_flush = 1'b1;
    q_flush_addr = 20'h00400;
    tick();
    q_flush = 1'b0;
    tick();
    tick();
    q_flush = 1'b1;
    q_flush_addr = 20'h00500;
    q_pop = 1'b1;
    @(negedge clk);
    chk("pre_flush_count", {29'h0, q_count}, 32'd4);
    chk("flush_no_fetch", {31'b0, ram_rd_en}, 32'd0);
    tick();
    q_flush = 1'b0;
    q_pop = 1'b0;
    @(negedge clk);
    chk("flush4_count", {29'h0, q_count}, 32'd0);
    chk("flush4_valid", {31'b0, q_valid}, 32'd0);
    tick();
    q_pop = 1'b1;
    repeat (6) tick();
    q_pop = 1'b0;

    // randomized traffic: data accesses alongside pops and flushes
    fork
      begin
        for (int k = 0; k < 60; k++)
          do_access(1'($urandom), 1'($urandom), 20'h40000 + 20'($urandom_range(0, 2046)),
                    16'($urandom));
        drain();
      end
      begin
        for (int k = 0; k < 400; k++) begin
          q_pop = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 24) == 0) begin
            q_flush = 1'b1;
            q_flush_addr = 20'h20000 + 20'($urandom_range(0, 1023));
          end else begin
            q_flush = 1'b0;
          end
          tick();
        end
        q_pop = 1'b0;
        q_flush = 1'b0;
      end
    join

    repeat (12) tick();
    @(negedge clk);
    chk("refill_full", {29'h0, q_count}, 32'd6);
    chk("pops_seen", {31'b0, pops_checked > 20}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
